// File: rtl/ntt_bank_loader.sv
// ntt_bank_loader
// Streams one 512-coefficient polynomial into four NTT memory banks.
// Each accepted coefficient is conditionally reduced by one subtraction
// of Q and written one cycle later to bank (mapping below), word index[8:2].
//
// Build option: define LOADER_SKEW_EN to use the skewed bank mapping
//    bank = (idx[1:0]+idx[3:2]+idx[5:4]+idx[7:6]+idx[8]) mod 4
// which keeps radix-4 butterfly operands in distinct banks. Without it
// the mapping is the plain interleave bank = idx[1:0].
//
// Ports
//    clk       single clock, rising edge
//    rst       asynchronous active-low reset
//    start     one-cycle load request (honoured only when idle)
//    s_valid   upstream coefficient valid
//    s_data    coefficient, natural order, index 0 first
//    s_ready   loader accepts a coefficient this cycle
//    wr_en     one-hot bank write strobe
//    wr_addr   word address within the selected bank
//    wr_data   reduced coefficient
//    busy      high from the accepted start until the done cycle
//    done      one-cycle pulse after the last bank write
//
// state | meaning
// IDLE  | waiting for start, s_ready low
// LOAD  | accepting coefficients, index counter advances per beat
// FLUSH | last write (index 511) on the bank port
// DONE  | done pulse, back to IDLE next cycle

module ntt_bank_loader #(
   parameter int DATA_W = 14,
   parameter int Q      = 12289
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic [3:0]        wr_en,
   output logic [6:0]        wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [DATA_W:0] Q_EXT = (DATA_W+1)'(Q);

   state_t            state;
   logic [8:0]        idx;
   logic [DATA_W:0]   data_ext;
   logic [DATA_W:0]   data_sub;
   logic [DATA_W-1:0] data_red;
   logic [1:0]        bank;
   logic [3:0]        bank_onehot;

   // Single conditional subtraction; inputs >= 2Q stay partially reduced.
   always_comb begin
      data_ext = {1'b0, s_data};
      data_sub = data_ext - Q_EXT;
      data_red = s_data;
      if (data_ext >= Q_EXT) begin
         data_red = data_sub[DATA_W-1:0];
      end
   end

   // Two-bit sum wraps naturally, giving the mod-4 reduction for free.
   always_comb begin
`ifdef LOADER_SKEW_EN
      bank = idx[1:0] + idx[3:2] + idx[5:4] + idx[7:6] + {1'b0, idx[8]};
`else
      bank = idx[1:0];
`endif
      bank_onehot = 4'b0001 << bank;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         idx     <= '0;
         s_ready <= 1'b0;
         wr_en   <= '0;
         wr_addr <= '0;
         wr_data <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         wr_en <= '0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= LOAD;
                  idx     <= '0;
                  s_ready <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            LOAD: begin
               if (s_valid && s_ready) begin
                  wr_en   <= bank_onehot;
                  wr_addr <= idx[8:2];
                  wr_data <= data_red;
                  idx     <= idx + 9'd1;
                  if (idx == 9'd511) begin
                     state   <= FLUSH;
                     s_ready <= 1'b0;
                  end
               end
            end
            FLUSH: begin
               state <= DONE;
               done  <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               s_ready <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ntt_bank_loader.sv
// Testbench for ntt_bank_loader: table-driven reduction vectors, directed
// polynomial runs, and randomized valid/data streams checked every cycle
// against a count-based reference model of the loader's behaviour.

module tb_ntt_bank_loader;

   localparam int DATA_W = 14;
   localparam int Q      = 12289;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              s_valid = 1'b0;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_ready;
   logic [3:0]        wr_en;
   logic [6:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              busy;
   logic              done;

   ntt_bank_loader #(.DATA_W(DATA_W), .Q(Q)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_ready (s_ready),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // reference model: number of accepted beats and cycles since the last one
   bit   m_active;
   int   m_loaded;
   int   m_after;
   logic [3:0] e_wr_en;
   int   e_addr, e_data, e_idx;
   bit   e_done;

   int wr_total, done_cnt;
   int bank_cnt [4];

   typedef struct {
      int din;
      int dexp;
   } red_vec_t;
   red_vec_t tbl [8];

`ifdef LOADER_SKEW_EN
   localparam logic [3:0] BANK_IDX5   = 4'b0100;
   localparam logic [3:0] BANK_IDX511 = 4'b0010;
`else
   localparam logic [3:0] BANK_IDX5   = 4'b0010;
   localparam logic [3:0] BANK_IDX511 = 4'b1000;
`endif

   function automatic int reduce(int d);
      return (d >= Q) ? ((d - Q) % (1 << DATA_W)) : d;
   endfunction

   function automatic int bank_of(int i);
`ifdef LOADER_SKEW_EN
      return ((i % 4) + ((i / 4) % 4) + ((i / 16) % 4) + ((i / 64) % 4) + ((i / 256) % 2)) % 4;
`else
      return i % 4;
`endif
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit acc;
      acc     = s_valid && m_active && (m_loaded < 512);
      e_wr_en = 4'b0000;
      e_done  = 1'b0;
      e_idx   = -1;
      if (!m_active) begin
         if (start) begin
            m_active = 1'b1;
            m_loaded = 0;
         end
      end else if (m_loaded < 512) begin
         if (acc) begin
            e_idx   = m_loaded;
            e_wr_en = 4'(1 << bank_of(m_loaded));
            e_addr  = m_loaded / 4;
            e_data  = reduce(int'(s_data));
            m_loaded++;
            if (m_loaded == 512) m_after = 0;
         end
      end else begin
         m_after++;
         if (m_after == 1) e_done = 1'b1;
         if (m_after == 2) m_active = 1'b0;
      end
   endtask

   task automatic step(bit v, int d, bit st);
      @(negedge clk);
      s_valid = v;
      s_data  = d[DATA_W-1:0];
      start   = st;
      @(posedge clk);
      model_edge();
      #1;
      chk("s_ready", 32'(s_ready), 32'(m_active && m_loaded < 512));
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(e_done));
      chk("wr_en", 32'(wr_en), 32'(e_wr_en));
      if (e_wr_en != 4'b0000) begin
         chk("wr_addr", 32'(wr_addr), 32'(e_addr));
         chk("wr_data", 32'(wr_data), 32'(e_data));
      end
      if (e_idx == 5) begin
         chk("bank_idx5", 32'(wr_en), 32'(BANK_IDX5));
         chk("addr_idx5", 32'(wr_addr), 32'd1);
      end
      if (e_idx == 511) begin
         chk("bank_idx511", 32'(wr_en), 32'(BANK_IDX511));
         chk("addr_idx511", 32'(wr_addr), 32'd127);
      end
      if (wr_en != 4'b0000) begin
         wr_total++;
         for (int b = 0; b < 4; b++) if (wr_en[b]) bank_cnt[b]++;
      end
      if (done) done_cnt++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst     = 1'b0;
      start   = 1'b0;
      s_valid = 1'b0;
      #1;
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      m_active = 1'b0;
      m_loaded = 0;
      m_after  = 0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic start_poly();
      wr_total = 0;
      done_cnt = 0;
      for (int b = 0; b < 4; b++) bank_cnt[b] = 0;
      step(1'b0, 0, 1'b1);
   endtask

   // mode 0: s_valid high, s_data=index; 1: valid toggles 1,0 with stray
   // start pulses; 2: random valid and data
   task automatic finish_poly(int mode, string tag);
      int  n;
      bit  v, st;
      int  d;
      n = 0;
      while (m_active && n < 3000) begin
         case (mode)
            0:       begin v = 1'b1; d = m_loaded; st = 1'b0; end
            1:       begin v = (n % 2 == 0); d = $urandom_range(0, 16383); st = ($urandom_range(0, 6) == 0); end
            default: begin v = ($urandom_range(0, 3) != 0); d = $urandom_range(0, 16383); st = ($urandom_range(0, 9) == 0); end
         endcase
         // a start sampled in the DONE cycle must not be queued
         if (m_loaded == 512 && m_after == 1) st = 1'b1;
         step(v, d, st);
         n++;
      end
      if (m_active) chk({tag, "_timeout"}, 32'd1, 32'd0);
      for (int k = 0; k < 4; k++) step(1'b0, 0, 1'b0);
      chk({tag, "_writes"}, 32'(wr_total), 32'd512);
      for (int b = 0; b < 4; b++) chk({tag, "_bank_cnt"}, 32'(bank_cnt[b]), 32'd128);
      chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
   endtask

   initial begin
      tbl[0] = '{din: 0,     dexp: 0};
      tbl[1] = '{din: 12288, dexp: 12288};
      tbl[2] = '{din: 12289, dexp: 0};
      tbl[3] = '{din: 16383, dexp: 4094};
      tbl[4] = '{din: 12290, dexp: 1};
      tbl[5] = '{din: 1,     dexp: 1};
      tbl[6] = '{din: 8000,  dexp: 8000};
      tbl[7] = '{din: 15000, dexp: 2711};

      m_active = 1'b0;
      m_loaded = 0;
      m_after  = 0;
      do_reset();
      for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b0);

      // index stream, valid held high
      start_poly();
      finish_poly(0, "ramp");

      // reduction table on the first beats, then random traffic
      start_poly();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, tbl[i].din, 1'b0);
         chk("tbl_wr_data", 32'(wr_data), 32'(tbl[i].dexp));
      end
      finish_poly(2, "rand");

      // alternating valid with start pulses during LOAD and DONE
      start_poly();
      finish_poly(1, "toggle");

      // reset after 200 beats abandons the load
      start_poly();
      for (int i = 0; i < 200; i++) step(1'b1, $urandom_range(0, 16383), 1'b0);
      do_reset();
      done_cnt = 0;
      for (int k = 0; k < 5; k++) step(1'b1, 0, 1'b0);
      chk("no_stale_done", 32'(done_cnt), 32'd0);
      start_poly();
      finish_poly(0, "restart");

      // second random polynomial
      start_poly();
      finish_poly(2, "rand2");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
